// File: rtl/fft_sequencer_if.sv
// Clock/reset bundle shared by blocks in this codebase.
// rst is asynchronous and active-high.
interface clk_rstn_intrf;
  logic clk;
  logic rst;

  modport master (
    output clk,
    output rst
  );

  modport slave (
    input clk,
    input rst
  );
endinterface

// File: rtl/fft_sequencer.sv
// In-place FFT pass sequencer: walks every butterfly of every stage,
// reading words A and B into a data-register pair, exchanging them and
// writing them back. Six cycles per butterfly; hold_i freezes the walk.
// LOG2N legal range is 2..10.
module fft_sequencer #(
  parameter int unsigned LOG2N = 4
) (
  clk_rstn_intrf.slave              clk_rstn_i,
  input  logic                      start_i,
  input  logic                      hold_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [LOG2N-1:0]          mem_addr_o,
  output logic                      mem_rden_o,
  output logic                      mem_wren_o,
  output logic                      reg_sel_o,
  output logic                      reg_wren_o,
  output logic                      reg_exchange_o,
  output logic [LOG2N-2:0]          twiddle_idx_o,
  output logic [$clog2(LOG2N)-1:0]  stage_o
);

  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned BW = LOG2N - 1;
  localparam logic [SW-1:0]    S_LAST   = SW'(LOG2N - 1);
  localparam logic [LOG2N-1:0] ADDR_ONE = LOG2N'(1);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CAP_B, XCHG, WR_A, WR_B, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [BW-1:0]    b_q, b_d;

  logic [LOG2N-1:0] span, pos, grp, addr_a, addr_b;
  logic [LOG2N-2:0] twiddle;
  int unsigned      tw_shift;

  // State, stage and butterfly registers
  always_ff @(posedge clk_rstn_i.clk or posedge clk_rstn_i.rst) begin
    if (clk_rstn_i.rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
    end
  end

  // Next state and counter advance; hold_i freezes everything except IDLE
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    if (state_q == IDLE) begin
      if (start_i) begin
        s_d     = '0;
        b_d     = '0;
        state_d = RD_A;
      end
    end else if (!hold_i) begin
      case (state_q)
        RD_A:  state_d = RD_B;
        RD_B:  state_d = CAP_B;
        CAP_B: state_d = XCHG;
        XCHG:  state_d = WR_A;
        WR_A:  state_d = WR_B;
        WR_B: begin
          if (b_q == '1) begin
            b_d = '0;
            // s is returned to 0 on the last stage so IDLE/DONE decode to zero
            if (s_q == S_LAST) begin
              s_d     = '0;
              state_d = DONE;
            end else begin
              s_d     = s_q + SW'(1);
              state_d = RD_A;
            end
          end else begin
            b_d     = b_q + BW'(1);
            state_d = RD_A;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Butterfly addresses: insert a zero bit at position s of b to get A
  always_comb begin
    span     = ADDR_ONE << s_q;
    pos      = {1'b0, b_q} & (span - ADDR_ONE);
    grp      = {1'b0, b_q} >> s_q;
    addr_a   = ((grp << s_q) << 1) | pos;
    addr_b   = addr_a + span;
    tw_shift = (LOG2N - 1) - 32'(s_q);
    twiddle  = pos[LOG2N-2:0] << tw_shift;
  end

  // Output decode from registered state; hold_i only gates the strobes
  always_comb begin
    busy_o         = (state_q != IDLE);
    done_o         = (state_q == DONE) && !hold_i;
    mem_rden_o     = ((state_q == RD_A) || (state_q == RD_B)) && !hold_i;
    mem_wren_o     = ((state_q == WR_A) || (state_q == WR_B)) && !hold_i;
    reg_wren_o     = ((state_q == RD_B) || (state_q == CAP_B)) && !hold_i;
    reg_exchange_o = (state_q == XCHG) && !hold_i;
    reg_sel_o      = (state_q == CAP_B) || (state_q == WR_B);
    twiddle_idx_o  = twiddle;
    stage_o        = s_q;
    mem_addr_o     = '0;
    case (state_q)
      RD_A, XCHG, WR_A:  mem_addr_o = addr_a;
      RD_B, CAP_B, WR_B: mem_addr_o = addr_b;
      default:           mem_addr_o = '0;
    endcase
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer with a behavioural RAM and
// data-register pair; expected butterflies come from a stage/group/pos walk.
module tb_fft_sequencer;

  localparam int L        = 4;
  localparam int N        = 16;
  localparam int HALF     = 8;
  localparam int NBFLY    = L * HALF;
  localparam int PASS_LEN = L * HALF * 6 + 1;

  typedef struct {
    int s;
    int a;
    int b;
    int tw;
  } bfly_t;

  typedef struct {
    int s;
    int b;
    int a;
    int bb;
    int tw;
  } vec_t;

  clk_rstn_intrf rif();

  logic       start_i, hold_i;
  logic       busy_o, done_o;
  logic [3:0] mem_addr_o;
  logic       mem_rden_o, mem_wren_o;
  logic       reg_sel_o, reg_wren_o, reg_exchange_o;
  logic [2:0] twiddle_idx_o;
  logic [1:0] stage_o;

  fft_sequencer #(.LOG2N(L)) dut (
    .clk_rstn_i     (rif),
    .start_i        (start_i),
    .hold_i         (hold_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .mem_addr_o     (mem_addr_o),
    .mem_rden_o     (mem_rden_o),
    .mem_wren_o     (mem_wren_o),
    .reg_sel_o      (reg_sel_o),
    .reg_wren_o     (reg_wren_o),
    .reg_exchange_o (reg_exchange_o),
    .twiddle_idx_o  (twiddle_idx_o),
    .stage_o        (stage_o)
  );

  initial begin
    rif.clk = 1'b0;
    forever #5 rif.clk = ~rif.clk;
  end

  int    checks, errors;
  bfly_t exp_q[$];
  bfly_t cur;
  vec_t  vecs[6];
  logic [7:0] ram_m[N];
  logic [7:0] ref_m[N];
  logic [7:0] rdata_m, r0, r1;
  int    busy_cnt, done_cnt, done_at, bfly_cnt, viol;
  int    obs_a[NBFLY], obs_b[NBFLY], obs_tw[NBFLY], obs_s[NBFLY];

  logic       sn_busy, sn_rden, sn_wren, sn_sel, sn_wr, sn_x, sn_done;
  logic [3:0] sn_addr;
  logic [2:0] sn_tw;
  int         sn_word;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int out_word();
    return int'({busy_o, done_o, mem_addr_o, mem_rden_o, mem_wren_o, reg_sel_o,
                 reg_wren_o, reg_exchange_o, twiddle_idx_o, stage_o});
  endfunction

  task automatic preload();
    for (int i = 0; i < N; i++) begin
      ram_m[i] = 8'(i * 37 + 11);
      ref_m[i] = ram_m[i];
    end
  endtask

  // Expected butterfly order and reference permutation for one pass
  task automatic push_pass();
    bfly_t      e;
    int         span;
    logic [7:0] tmp;
    for (int s = 0; s < L; s++) begin
      span = 1 << s;
      for (int g = 0; g < N / (2 * span); g++) begin
        for (int p = 0; p < span; p++) begin
          e.s  = s;
          e.a  = g * 2 * span + p;
          e.b  = e.a + span;
          e.tw = p * (HALF / span);
          exp_q.push_back(e);
          tmp        = ref_m[e.a];
          ref_m[e.a] = ref_m[e.b];
          ref_m[e.b] = tmp;
        end
      end
    end
  endtask

  // One clock: sample at negedge, score, update RAM/register model, return at posedge+1
  task automatic cycle();
    logic [7:0] old_rd;
    @(negedge rif.clk);
    sn_busy = busy_o;  sn_done = done_o;  sn_rden = mem_rden_o;
    sn_wren = mem_wren_o; sn_sel = reg_sel_o; sn_wr = reg_wren_o;
    sn_x    = reg_exchange_o; sn_addr = mem_addr_o; sn_tw = twiddle_idx_o;
    sn_word = out_word();
    if (mem_rden_o && mem_wren_o) viol++;
    if (reg_exchange_o && reg_wren_o) viol++;
    if (busy_o) busy_cnt++;
    if (done_o) begin
      done_cnt++;
      done_at = busy_cnt;
    end
    if (mem_rden_o && !reg_wren_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: RD_A at addr %0d with no expected butterfly", mem_addr_o);
      end else begin
        cur = exp_q.pop_front();
        chk("rd_a_addr", int'(mem_addr_o), cur.a);
        chk("rd_a_stage", int'(stage_o), cur.s);
        chk("rd_a_twiddle", int'(twiddle_idx_o), cur.tw);
        if (bfly_cnt < NBFLY) begin
          obs_a[bfly_cnt]  = int'(mem_addr_o);
          obs_tw[bfly_cnt] = int'(twiddle_idx_o);
          obs_s[bfly_cnt]  = int'(stage_o);
        end
      end
      bfly_cnt++;
    end
    if (mem_rden_o && reg_wren_o) begin
      chk("rd_b_addr", int'(mem_addr_o), cur.b);
      if (bfly_cnt >= 1 && bfly_cnt <= NBFLY) obs_b[bfly_cnt-1] = int'(mem_addr_o);
    end
    old_rd = rdata_m;
    if (mem_wren_o) ram_m[mem_addr_o] = reg_sel_o ? r1 : r0;
    if (mem_rden_o) rdata_m = ram_m[mem_addr_o];
    if (reg_wren_o) begin
      if (reg_sel_o) r1 = old_rd;
      else           r0 = old_rd;
    end
    if (reg_exchange_o) begin
      old_rd = r0;
      r0     = r1;
      r1     = old_rd;
    end
    @(posedge rif.clk);
    #1;
  endtask

  task automatic run_pass(input bit start_hold, input int restart_at, input int hold_bfly,
                          input int exp_len, input string tag);
    int         hold_left;
    bit         held_now, prev_held, first_held, finished, hold_used;
    logic [3:0] h_addr;
    logic [2:0] h_tw;
    logic       h_sel;
    hold_left = 0; held_now = 0; prev_held = 0; first_held = 1;
    finished = 0; hold_used = 0; h_addr = '0; h_tw = '0; h_sel = 1'b0;
    preload();
    push_pass();
    busy_cnt = 0; done_cnt = 0; done_at = -1; bfly_cnt = 0; viol = 0;
    start_i = 1'b1;
    hold_i  = start_hold;
    cycle();
    start_i = 1'b0;
    hold_i  = 1'b0;
    for (int c = 0; c < 600 && !finished; c++) begin
      start_i  = (restart_at > 0) && (busy_cnt == restart_at);
      held_now = (hold_left > 0);
      hold_i   = held_now;
      if (held_now) hold_left--;
      cycle();
      if (held_now) begin
        chk($sformatf("%s_hold_strobes", tag),
            int'({sn_rden, sn_wren, sn_wr, sn_x, sn_done}), 0);
        if (first_held) begin
          h_addr = sn_addr; h_tw = sn_tw; h_sel = sn_sel;
          first_held = 0;
        end else begin
          chk($sformatf("%s_hold_addr", tag), int'(sn_addr), int'(h_addr));
          chk($sformatf("%s_hold_tw", tag), int'(sn_tw), int'(h_tw));
          chk($sformatf("%s_hold_sel", tag), int'(sn_sel), int'(h_sel));
        end
      end else if (prev_held) begin
        chk($sformatf("%s_capb_reexec", tag), int'({sn_wr, sn_sel, sn_rden}), 6);
        chk($sformatf("%s_release_addr", tag), int'(sn_addr), int'(h_addr));
        chk($sformatf("%s_release_tw", tag), int'(sn_tw), int'(h_tw));
      end
      prev_held = held_now;
      if (hold_bfly >= 0 && !hold_used && sn_rden && sn_wr && bfly_cnt == hold_bfly + 1) begin
        hold_left = 3;
        hold_used = 1;
      end
      if (busy_cnt > 0 && !sn_busy) finished = 1;
    end
    start_i = 1'b0;
    hold_i  = 1'b0;
    chk($sformatf("%s_completed", tag), int'(finished), 1);
    chk($sformatf("%s_busy_len", tag), busy_cnt, exp_len);
    chk($sformatf("%s_done_pulses", tag), done_cnt, 1);
    chk($sformatf("%s_done_last_busy", tag), done_at, exp_len);
    chk($sformatf("%s_butterflies", tag), bfly_cnt, NBFLY);
    chk($sformatf("%s_exclusive_strobes", tag), viol, 0);
    chk($sformatf("%s_sb_drained", tag), exp_q.size(), 0);
    if (hold_bfly >= 0) chk($sformatf("%s_hold_applied", tag), int'(hold_used), 1);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_ram[%0d]", tag, i), int'(ram_m[i]), int'(ref_m[i]));
  endtask

  initial begin
    checks = 0; errors = 0;
    start_i = 1'b0; hold_i = 1'b0;
    rdata_m = '0; r0 = '0; r1 = '0;
    cur = '{0, 0, 0, 0};
    vecs[0] = '{0, 3, 6, 7, 0};
    vecs[1] = '{3, 5, 5, 13, 5};
    vecs[2] = '{1, 2, 4, 6, 0};
    vecs[3] = '{2, 7, 11, 15, 6};
    vecs[4] = '{0, 0, 0, 1, 0};
    vecs[5] = '{3, 7, 7, 15, 7};

    rif.rst = 1'b1;
    repeat (2) @(posedge rif.clk);
    #1;
    chk("reset_outputs_zero", out_word(), 0);
    rif.rst = 1'b0;
    cycle();
    chk("idle_not_busy", int'(sn_busy), 0);

    run_pass(1'b0, 0, -1, PASS_LEN, "p1");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec%0d_A", i), obs_a[vecs[i].s * HALF + vecs[i].b], vecs[i].a);
      chk($sformatf("vec%0d_B", i), obs_b[vecs[i].s * HALF + vecs[i].b], vecs[i].bb);
      chk($sformatf("vec%0d_tw", i), obs_tw[vecs[i].s * HALF + vecs[i].b], vecs[i].tw);
      chk($sformatf("vec%0d_stage", i), obs_s[vecs[i].s * HALF + vecs[i].b], vecs[i].s);
    end

    run_pass(1'b1, 50, -1, PASS_LEN, "p2_restart");
    run_pass(1'b0, 0, 5, PASS_LEN + 3, "p3_hold");

    // Abort mid-pass with reset during stage 2
    preload();
    push_pass();
    bfly_cnt = 0;
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    for (int c = 0; c < 400 && stage_o != 2'd2; c++) cycle();
    chk("abort_reached_stage2", int'(stage_o), 2);
    rif.rst = 1'b1;
    #1;
    chk("abort_outputs_zero", out_word(), 0);
    exp_q.delete();
    cycle();
    chk("abort_held_zero", sn_word, 0);
    rif.rst = 1'b0;
    chk("after_reset_stage", int'(stage_o), 0);
    run_pass(1'b0, 0, -1, PASS_LEN, "p4_after_reset");
    chk("restart_first_A", obs_a[0], 0);
    chk("restart_first_B", obs_b[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
